// File: rtl/svm_decision.sv
// rtl/svm_decision.sv - alpha-weighted accumulation of SVM kernel dot products into scored decisions
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   dot_valid   dot_in carries a kernel dot product this cycle (no backpressure)
//   dot_in      signed dot product for support vector sv_cnt
//   alphas      signed dual coefficients, alphas[i] weights support vector i
//   bias        signed bias added to each finished sum
//   abort       drop the partial group and the S1/S2 contents
//   out_valid   output FIFO non-empty
//   out_ready   consumer takes the head entry
//   out_score   signed score at the FIFO head (0 when empty)
//   out_label   1 when out_score >= 0 (0 when empty)
//   overflow    sticky: a finished decision found the FIFO full and was dropped
//   busy        group in progress or S1/S2 holding data
module svm_decision #(
  parameter int DATA_SIZE  = 32,
  parameter int ACCUM_SIZE = 64,
  parameter int COEF_SIZE  = 32,
  parameter int NUM_SV     = 3,
  parameter int OUT_DEPTH  = 4,
  localparam int SUM_SIZE  = ACCUM_SIZE + COEF_SIZE + $clog2(NUM_SV) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dot_valid,
  input  logic [ACCUM_SIZE-1:0]            dot_in,
  input  logic [NUM_SV-1:0][COEF_SIZE-1:0] alphas,
  input  logic [SUM_SIZE-1:0]              bias,
  input  logic                             abort,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SUM_SIZE-1:0]              out_score,
  output logic                             out_label,
  output logic                             overflow,
  output logic                             busy
);

  localparam int SV_W  = $clog2(NUM_SV);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam logic [SV_W-1:0]  LAST_SV   = SV_W'(NUM_SV - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(OUT_DEPTH);

  // DATA_SIZE only shapes hw_svm upstream; it appears here so both blocks
  // share one parameter list. The empty block is never elaborated.
  if (DATA_SIZE < 1) begin : g_data_size_guard
  end

  // ---------------- control FSM ----------------
  typedef enum logic {IDLE, ACCUM} state_t;

  state_t          state, state_next;
  logic [SV_W-1:0] sv_cnt, sv_cnt_next;
  logic            accept;
  logic            first_sv;
  logic            last_sv;

  // A dot arriving together with abort is discarded.
  assign accept   = dot_valid & ~abort;
  assign first_sv = (sv_cnt == '0);
  assign last_sv  = (sv_cnt == LAST_SV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sv_cnt <= '0;
    end else begin
      state  <= state_next;
      sv_cnt <= sv_cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    sv_cnt_next = sv_cnt;
    if (abort) begin
      state_next  = IDLE;
      sv_cnt_next = '0;
    end else if (dot_valid) begin
      if (last_sv) begin
        state_next  = IDLE;
        sv_cnt_next = '0;
      end else begin
        state_next  = ACCUM;
        sv_cnt_next = sv_cnt + SV_W'(1);
      end
    end
  end

  // ---------------- S1: weighted product ----------------
  logic [COEF_SIZE-1:0]       alpha_sel;
  logic signed [SUM_SIZE-1:0] dot_ext;
  logic signed [SUM_SIZE-1:0] alpha_ext;
  logic signed [SUM_SIZE-1:0] prod;

  assign alpha_sel = alphas[sv_cnt];
  assign dot_ext   = {{(SUM_SIZE - ACCUM_SIZE){dot_in[ACCUM_SIZE-1]}}, dot_in};
  assign alpha_ext = {{(SUM_SIZE - COEF_SIZE){alpha_sel[COEF_SIZE-1]}}, alpha_sel};
  // Both operands are sign-extended to SUM_SIZE, so the low SUM_SIZE bits of
  // this product are the exact full-precision product.
  assign prod      = dot_ext * alpha_ext;

  logic                       s1_valid;
  logic                       s1_first;
  logic                       s1_last;
  logic signed [SUM_SIZE-1:0] s1_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod  <= prod;
        s1_first <= first_sv;
        s1_last  <= last_sv;
      end
    end
  end

  // ---------------- S2: accumulator ----------------
  logic                       s2_valid;
  logic                       s2_done;
  logic signed [SUM_SIZE-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_done  <= 1'b0;
      acc      <= '0;
    end else if (abort) begin
      s2_valid <= 1'b0;
      s2_done  <= 1'b0;
      acc      <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_done  <= s1_valid & s1_last;
      // acc holds across input gaps; the first product of a group restarts it.
      if (s1_valid) begin
        acc <= s1_first ? s1_prod : acc + s1_prod;
      end
    end
  end

  // ---------------- S3: bias and label ----------------
  // S3 ignores abort: a sum that finished in S2 still becomes a decision.
  logic                       s3_valid;
  logic                       s3_label;
  logic [SUM_SIZE-1:0]        s3_score;
  logic signed [SUM_SIZE-1:0] score_sum;

  assign score_sum = acc + $signed(bias);

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_label <= 1'b0;
      s3_score <= '0;
    end else begin
      s3_valid <= s2_done;
      if (s2_done) begin
        s3_score <= score_sum;
        s3_label <= ~score_sum[SUM_SIZE-1];
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [SUM_SIZE-1:0]  score_mem [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] label_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 full;
  logic                 pop;
  logic                 push_ok;

  assign full      = (count == FIFO_FULL);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = s3_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (s3_valid & full & ~pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      score_mem[wr_ptr] <= s3_score;
      label_mem[wr_ptr] <= s3_label;
    end
  end

  assign out_score = out_valid ? score_mem[rd_ptr] : '0;
  assign out_label = out_valid & label_mem[rd_ptr];
  assign busy      = (state == ACCUM) | s1_valid | s2_valid;

endmodule
